// File: rtl/alu_op_sequencer_pkg.sv
// Shared definitions for the ALU operation sequencer.
// Contents:
//   - instruction field positions and widths (OP, DEST, SRC1, SRC2, WB, RPT)
//   - the packed instruction struct and a decode helper
//   - the sequencer FSM state encoding
package alu_op_sequencer_pkg;

  localparam int INSTR_W  = 12;

  localparam int OP_LSB   = 9;
  localparam int OP_W     = 3;
  localparam int DEST_LSB = 7;
  localparam int DEST_W   = 2;
  localparam int SRC1_LSB = 5;
  localparam int SRC2_LSB = 3;
  localparam int SRC_W    = 2;
  localparam int WB_BIT   = 2;
  localparam int RPT_LSB  = 0;
  localparam int RPT_W    = 2;

  typedef struct packed {
    logic [OP_W-1:0]   op;
    logic [DEST_W-1:0] dest;
    logic [SRC_W-1:0]  src1;
    logic [SRC_W-1:0]  src2;
    logic              wb;
    logic [RPT_W-1:0]  rpt;
  } instr_t;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_ISSUE = 1'b1
  } state_e;

  // Split a raw instruction word into its named fields.
  function automatic instr_t decode_instr(input logic [INSTR_W-1:0] raw);
    instr_t d;
    d.op   = raw[OP_LSB +: OP_W];
    d.dest = raw[DEST_LSB +: DEST_W];
    d.src1 = raw[SRC1_LSB +: SRC_W];
    d.src2 = raw[SRC2_LSB +: SRC_W];
    d.wb   = raw[WB_BIT];
    d.rpt  = raw[RPT_LSB +: RPT_W];
    return d;
  endfunction

endpackage

// File: rtl/alu_op_sequencer_if.sv
// Bus interface of the ALU operation sequencer.
// Groups three streams:
//   - instruction input  : in_valid, in_ready, in_instr
//   - datapath controls  : addr1, addr2, addr3, alu, wr (out) / result, cout (in)
//   - completion + status: out_valid, out_data, out_cout, busy, issued_cnt
// master = environment (instruction source + datapath), slave = sequencer.
interface alu_op_sequencer_if
  import alu_op_sequencer_pkg::*;
#(
  parameter int DW = 32,
  parameter int CW = 16
);

  logic               in_valid;
  logic               in_ready;
  logic [INSTR_W-1:0] in_instr;

  logic [SRC_W-1:0]   addr1;
  logic [SRC_W-1:0]   addr2;
  logic [DEST_W-1:0]  addr3;
  logic [OP_W-1:0]    alu;
  logic               wr;
  logic [DW-1:0]      result;
  logic               cout;

  logic               out_valid;
  logic [DW-1:0]      out_data;
  logic               out_cout;
  logic               busy;
  logic [CW-1:0]      issued_cnt;

  modport master (
    output in_valid, in_instr, result, cout,
    input  in_ready, addr1, addr2, addr3, alu, wr,
    input  out_valid, out_data, out_cout, busy, issued_cnt
  );

  modport slave (
    input  in_valid, in_instr, result, cout,
    output in_ready, addr1, addr2, addr3, alu, wr,
    output out_valid, out_data, out_cout, busy, issued_cnt
  );

endinterface

// File: rtl/alu_op_sequencer_instr_fifo.sv
// Synchronous instruction FIFO, DEPTH entries of INSTR_W bits.
// Ports:
//   clk, rst     : clock, asynchronous active-high reset (empties the FIFO)
//   push_i       : write wdata_i at the rising edge (ignored when full)
//   wdata_i      : instruction word to store
//   pop_i        : drop the head entry at the rising edge (ignored when empty)
//   rdata_o      : head entry (valid while empty_o = 0)
//   full_o       : no free entry
//   empty_o      : no stored entry
module alu_op_sequencer_instr_fifo
  import alu_op_sequencer_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               push_i,
  input  logic [INSTR_W-1:0] wdata_i,
  input  logic               pop_i,
  output logic [INSTR_W-1:0] rdata_o,
  output logic               full_o,
  output logic               empty_o
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] CNT_FULL = (PW+1)'(DEPTH);

  logic [INSTR_W-1:0] mem_q [DEPTH];
  logic [PW-1:0]      wr_ptr_q;
  logic [PW-1:0]      rd_ptr_q;
  logic [PW:0]        count_q;
  logic               do_push;
  logic               do_pop;

  assign full_o  = (count_q == CNT_FULL);
  assign empty_o = (count_q == {(PW+1){1'b0}});
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;
  assign rdata_o = mem_q[rd_ptr_q];

  // Storage array: written on accepted pushes only, no reset needed.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

  // Pointers and occupancy count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= {PW{1'b0}};
      rd_ptr_q <= {PW{1'b0}};
      count_q  <= {(PW+1){1'b0}};
    end else begin
      if (do_push) begin
        wr_ptr_q <= wr_ptr_q + PW'(1'b1);
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + PW'(1'b1);
      end
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + (PW+1)'(1'b1);
        2'b01:   count_q <= count_q - (PW+1)'(1'b1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/alu_op_sequencer.sv
// ALU operation sequencer: accepts encoded ALU instructions, queues them in
// a small FIFO and drives the regfile/ALU datapath controls one operation per
// cycle (with optional repeats). Each issued operation's result/carry is
// captured and returned as a one-cycle completion pulse.
// Ports:
//   clk, rst : clock, asynchronous active-high reset
//   bus      : slave side of alu_op_sequencer_if
//              (instruction handshake, datapath controls/result, completion, status)
module alu_op_sequencer
  import alu_op_sequencer_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int DW    = 32,
  parameter int CW    = 16
) (
  input  logic             clk,
  input  logic             rst,
  alu_op_sequencer_if.slave bus
);

  logic               fifo_push;
  logic               fifo_pop;
  logic               fifo_full;
  logic               fifo_empty;
  logic [INSTR_W-1:0] fifo_rdata;
  instr_t             head;

  state_e             state_q;
  logic [RPT_W-1:0]   rem_q;
  logic [SRC_W-1:0]   addr1_q;
  logic [SRC_W-1:0]   addr2_q;
  logic [DEST_W-1:0]  addr3_q;
  logic [OP_W-1:0]    alu_q;
  logic               wr_q;
  logic               out_valid_q;
  logic [DW-1:0]      out_data_q;
  logic               out_cout_q;
  logic [CW-1:0]      issued_cnt_q;

  // in_ready depends on fullness alone: a pop in the same cycle does not
  // open a slot for a simultaneous push.
  assign fifo_push = bus.in_valid & ~fifo_full;
  assign head      = decode_instr(fifo_rdata);

  alu_op_sequencer_instr_fifo #(
    .DEPTH (DEPTH)
  ) u_instr_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (fifo_push),
    .wdata_i (bus.in_instr),
    .pop_i   (fifo_pop),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // Head is consumed when idle, or when the current instruction has no repeats left.
  always_comb begin
    fifo_pop = 1'b0;
    case (state_q)
      ST_IDLE:  fifo_pop = ~fifo_empty;
      ST_ISSUE: fifo_pop = (rem_q == {RPT_W{1'b0}}) & ~fifo_empty;
      default:  fifo_pop = 1'b0;
    endcase
  end

  // Sequencer FSM with registered datapath controls, completion and issue counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      rem_q        <= {RPT_W{1'b0}};
      addr1_q      <= {SRC_W{1'b0}};
      addr2_q      <= {SRC_W{1'b0}};
      addr3_q      <= {DEST_W{1'b0}};
      alu_q        <= {OP_W{1'b0}};
      wr_q         <= 1'b0;
      out_valid_q  <= 1'b0;
      out_data_q   <= {DW{1'b0}};
      out_cout_q   <= 1'b0;
      issued_cnt_q <= {CW{1'b0}};
    end else begin
      case (state_q)
        ST_IDLE: begin
          out_valid_q <= 1'b0;
          if (!fifo_empty) begin
            state_q <= ST_ISSUE;
            rem_q   <= head.rpt;
            addr1_q <= head.src1;
            addr2_q <= head.src2;
            addr3_q <= head.dest;
            alu_q   <= head.op;
            wr_q    <= head.wb;
          end else begin
            addr1_q <= {SRC_W{1'b0}};
            addr2_q <= {SRC_W{1'b0}};
            addr3_q <= {DEST_W{1'b0}};
            alu_q   <= {OP_W{1'b0}};
            wr_q    <= 1'b0;
          end
        end
        ST_ISSUE: begin
          // result is sampled before the regfile write of this same edge lands.
          issued_cnt_q <= issued_cnt_q + CW'(1'b1);
          out_data_q   <= bus.result;
          out_cout_q   <= bus.cout;
          out_valid_q  <= 1'b1;
          if (rem_q != {RPT_W{1'b0}}) begin
            rem_q <= rem_q - RPT_W'(1'b1);
          end else if (!fifo_empty) begin
            // Back-to-back: next instruction issues with no idle bubble.
            rem_q   <= head.rpt;
            addr1_q <= head.src1;
            addr2_q <= head.src2;
            addr3_q <= head.dest;
            alu_q   <= head.op;
            wr_q    <= head.wb;
          end else begin
            state_q <= ST_IDLE;
            addr1_q <= {SRC_W{1'b0}};
            addr2_q <= {SRC_W{1'b0}};
            addr3_q <= {DEST_W{1'b0}};
            alu_q   <= {OP_W{1'b0}};
            wr_q    <= 1'b0;
          end
        end
        default: begin
          state_q     <= ST_IDLE;
          rem_q       <= {RPT_W{1'b0}};
          addr1_q     <= {SRC_W{1'b0}};
          addr2_q     <= {SRC_W{1'b0}};
          addr3_q     <= {DEST_W{1'b0}};
          alu_q       <= {OP_W{1'b0}};
          wr_q        <= 1'b0;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready   = ~fifo_full;
  assign bus.addr1      = addr1_q;
  assign bus.addr2      = addr2_q;
  assign bus.addr3      = addr3_q;
  assign bus.alu        = alu_q;
  assign bus.wr         = wr_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_data   = out_data_q;
  assign bus.out_cout   = out_cout_q;
  assign bus.busy       = (state_q == ST_ISSUE) | ~fifo_empty;
  assign bus.issued_cnt = issued_cnt_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed self-checking bench for alu_op_sequencer. Models a 4-entry regfile
// plus ALU (0 add, 1 sub, 2 and, 3 or, 4 xor, others pass src1) as the datapath.
module tb_alu_op_sequencer;
  import alu_op_sequencer_pkg::*;

  localparam int DW = 32;
  localparam int CW = 16;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;

  alu_op_sequencer_if #(.DW(DW), .CW(CW)) bus();

  alu_op_sequencer #(.DEPTH(4), .DW(DW), .CW(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [DW-1:0] rf [4];
  logic          ld_en;
  logic [1:0]    ld_idx;
  logic [DW-1:0] ld_val;
  logic [DW:0]   alu_res;

  int            pushed;
  int            nissue;
  logic          rdy;
  logic          saw_full;
  logic [8:0]    got [24];
  logic [8:0]    exp_issue;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [DW:0] alu_model(input logic [2:0] op, input logic [DW-1:0] a,
                                            input logic [DW-1:0] b);
    case (op)
      3'd0:    return {1'b0, a} + {1'b0, b};
      3'd1:    return {1'b0, a - b};
      3'd2:    return {1'b0, a & b};
      3'd3:    return {1'b0, a | b};
      3'd4:    return {1'b0, a ^ b};
      default: return {1'b0, a};
    endcase
  endfunction

  function automatic logic [11:0] mk(input logic [2:0] op, input logic [1:0] d,
                                     input logic [1:0] s1, input logic [1:0] s2,
                                     input logic wb, input logic [1:0] rpt);
    return {op, d, s1, s2, wb, rpt};
  endfunction

  // Datapath regfile: bench preload port, otherwise written by the DUT's wr.
  always @(posedge clk) begin
    if (ld_en) rf[ld_idx] <= ld_val;
    else if (bus.wr) rf[bus.addr3] <= alu_res[DW-1:0];
  end

  always_comb begin
    alu_res    = alu_model(bus.alu, rf[bus.addr1], rf[bus.addr2]);
    bus.result = alu_res[DW-1:0];
    bus.cout   = alu_res[DW];
  end

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic set_rf(input logic [1:0] idx, input logic [DW-1:0] val);
    ld_en = 1'b1; ld_idx = idx; ld_val = val;
    @(posedge clk);
    @(negedge clk);
    ld_en = 1'b0;
  endtask

  // Called at a negedge; returns at the negedge after the handshake edge.
  task automatic push_one(input logic [11:0] ins);
    check_eq("push_ready", 64'(bus.in_ready), 64'(1));
    bus.in_valid = 1'b1; bus.in_instr = ins;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  initial begin
    n_checks = 0; n_errors = 0;
    rst = 1'b1; ld_en = 1'b0; ld_idx = 2'd0; ld_val = '0;
    bus.in_valid = 1'b0; bus.in_instr = 12'h000;

    // ---- reset state ----
    #3;
    check_eq("rst_wr", 64'(bus.wr), 64'(0));
    check_eq("rst_out_valid", 64'(bus.out_valid), 64'(0));
    check_eq("rst_out_data", 64'(bus.out_data), 64'(0));
    check_eq("rst_busy", 64'(bus.busy), 64'(0));
    check_eq("rst_cnt", 64'(bus.issued_cnt), 64'(0));
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    check_eq("rel_in_ready", 64'(bus.in_ready), 64'(1));

    // ---- single op: and r2,r3 -> r1 ----
    set_rf(2'd0, 32'h0000_0011);
    set_rf(2'd1, 32'h0000_00AA);
    set_rf(2'd2, 32'hF0F0_1234);
    set_rf(2'd3, 32'h0FF0_FF00);
    push_one(mk(3'b010, 2'd1, 2'd2, 2'd3, 1'b1, 2'd0));
    check_eq("t2_k0_wr", 64'(bus.wr), 64'(0));
    check_eq("t2_k0_busy", 64'(bus.busy), 64'(1));
    @(negedge clk);
    check_eq("t2_k1_ctl", 64'({bus.wr, bus.alu, bus.addr3, bus.addr1, bus.addr2}),
             64'({1'b1, 3'b010, 2'd1, 2'd2, 2'd3}));
    check_eq("t2_k1_ov", 64'(bus.out_valid), 64'(0));
    @(negedge clk);
    check_eq("t2_k2_wr", 64'(bus.wr), 64'(0));
    check_eq("t2_k2_ov", 64'(bus.out_valid), 64'(1));
    check_eq("t2_k2_data", 64'(bus.out_data), 64'(32'h00F0_1200));
    check_eq("t2_rf1", 64'(rf[1]), 64'(32'h00F0_1200));
    @(negedge clk);
    check_eq("t2_k3_ov", 64'(bus.out_valid), 64'(0));
    check_eq("t2_cnt", 64'(bus.issued_cnt), 64'(1));

    // ---- repeat 3: r0 += r1 four times ----
    set_rf(2'd0, 32'd0);
    set_rf(2'd1, 32'd5);
    push_one(mk(3'd0, 2'd0, 2'd0, 2'd1, 1'b1, 2'd3));
    for (int k = 0; k < 8; k++) begin
      check_eq("t3_wr", 64'(bus.wr), 64'((k >= 1 && k <= 4) ? 1 : 0));
      check_eq("t3_ov", 64'(bus.out_valid), 64'((k >= 2 && k <= 5) ? 1 : 0));
      if (k >= 2 && k <= 5) check_eq("t3_data", 64'(bus.out_data), 64'(5 * (k - 1)));
      @(negedge clk);
    end
    check_eq("t3_cnt", 64'(bus.issued_cnt), 64'(5));   // 1 earlier + 4 here
    check_eq("t3_rf0", 64'(rf[0]), 64'(20));

    // ---- back-to-back: xor r0,r1->r2 then sub r1,r0->r3 ----
    bus.in_valid = 1'b1; bus.in_instr = mk(3'd4, 2'd2, 2'd0, 2'd1, 1'b1, 2'd0);
    @(posedge clk);
    @(negedge clk);
    bus.in_instr = mk(3'd1, 2'd3, 2'd1, 2'd0, 1'b1, 2'd0);
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    check_eq("t4_k1_ctl", 64'({bus.wr, bus.addr3}), 64'({1'b1, 2'd2}));
    check_eq("t4_k1_ov", 64'(bus.out_valid), 64'(0));
    @(negedge clk);
    check_eq("t4_k2_ctl", 64'({bus.wr, bus.addr3}), 64'({1'b1, 2'd3}));
    check_eq("t4_k2_ov", 64'(bus.out_valid), 64'(1));
    check_eq("t4_k2_data", 64'(bus.out_data), 64'(32'd17));
    @(negedge clk);
    check_eq("t4_k3_wr", 64'(bus.wr), 64'(0));
    check_eq("t4_k3_ov", 64'(bus.out_valid), 64'(1));
    check_eq("t4_k3_data", 64'(bus.out_data), 64'(32'hFFFF_FFF1));
    @(negedge clk);
    check_eq("t4_k4_ov", 64'(bus.out_valid), 64'(0));

    // ---- six rpt=3 instructions streamed into a 4-deep FIFO ----
    pushed = 0; nissue = 0; saw_full = 1'b0;
    for (int c = 0; c < 45; c++) begin
      if (bus.wr) begin
        if (nissue < 24) got[nissue] = {bus.alu, bus.addr3, bus.addr1, bus.addr2};
        nissue++;
      end
      if (!bus.in_ready) saw_full = 1'b1;
      rdy = bus.in_ready;
      if (pushed < 6) begin
        bus.in_valid = 1'b1;
        bus.in_instr = mk(3'(pushed), 2'(pushed % 4), 2'((pushed + 1) % 4),
                          2'((pushed + 2) % 4), 1'b1, 2'd3);
      end else begin
        bus.in_valid = 1'b0;
      end
      @(posedge clk);
      if (bus.in_valid && rdy) pushed++;
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    check_eq("t5_pushed", 64'(pushed), 64'(6));
    check_eq("t5_saw_full", 64'(saw_full), 64'(1));
    check_eq("t5_nissue", 64'(nissue), 64'(24));
    for (int j = 0; j < 24; j++) begin
      exp_issue = {3'(j / 4), 2'((j / 4) % 4), 2'((j / 4 + 1) % 4), 2'((j / 4 + 2) % 4)};
      check_eq("t5_issue", 64'(got[j]), 64'(exp_issue));
    end
    check_eq("t5_cnt", 64'(bus.issued_cnt), 64'(31));
    check_eq("t5_idle", 64'(bus.busy), 64'(0));

    // ---- wb=0: add r3,r2 overflows, r0 untouched ----
    set_rf(2'd0, 32'h0000_1357);
    set_rf(2'd2, 32'hFFFF_FFF0);
    set_rf(2'd3, 32'h0000_0020);
    push_one(mk(3'd0, 2'd0, 2'd3, 2'd2, 1'b0, 2'd0));
    @(negedge clk);
    check_eq("t6_k1_ctl", 64'({bus.wr, bus.addr1, bus.addr2}), 64'({1'b0, 2'd3, 2'd2}));
    @(negedge clk);
    check_eq("t6_ov", 64'(bus.out_valid), 64'(1));
    check_eq("t6_data", 64'(bus.out_data), 64'(32'h0000_0010));
    check_eq("t6_cout", 64'(bus.out_cout), 64'(1));
    check_eq("t6_rf0", 64'(rf[0]), 64'(32'h0000_1357));
    check_eq("t6_cnt", 64'(bus.issued_cnt), 64'(32));
    @(negedge clk);

    // ---- reset in the middle of a repeat with one instruction queued ----
    push_one(mk(3'd3, 2'd1, 2'd2, 2'd3, 1'b1, 2'd3));
    push_one(mk(3'd4, 2'd2, 2'd0, 2'd1, 1'b1, 2'd0));
    check_eq("mr_pre_wr", 64'(bus.wr), 64'(1));
    #2;
    rst = 1'b1;
    #1;
    check_eq("mr_wr", 64'(bus.wr), 64'(0));
    check_eq("mr_addr3", 64'(bus.addr3), 64'(0));
    check_eq("mr_alu", 64'(bus.alu), 64'(0));
    check_eq("mr_busy", 64'(bus.busy), 64'(0));
    check_eq("mr_cnt", 64'(bus.issued_cnt), 64'(0));
    check_eq("mr_out_data", 64'(bus.out_data), 64'(0));
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_eq("mr_in_ready", 64'(bus.in_ready), 64'(1));
    repeat (3) @(negedge clk);
    check_eq("mr_after_wr", 64'(bus.wr), 64'(0));
    check_eq("mr_after_ov", 64'(bus.out_valid), 64'(0));
    check_eq("mr_after_busy", 64'(bus.busy), 64'(0));
    check_eq("mr_after_cnt", 64'(bus.issued_cnt), 64'(0));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
